// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and ALU function codes.
package cpu_pkg;

    localparam int unsigned DataWidth   = 16;
    localparam int unsigned RegIdxWidth = 4;

    typedef enum logic [3:0] {
        FnMul = 4'b0001,
        FnDiv = 4'b0010,
        FnRol = 4'b1000,
        FnRor = 4'b1001,
        FnShl = 4'b1010,
        FnShr = 4'b1011,
        FnOr  = 4'b1100,
        FnAnd = 4'b1101,
        FnSub = 4'b1110,
        FnAdd = 4'b1111
    } func_e;

    // MUL and DIV deposit a second result in R0 alongside rd.
    function automatic logic writes_r0(input logic [3:0] func);
        return (func == FnMul) || (func == FnDiv);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks the youngest in-flight producer of a source register,
// falling back to the register-file value.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth,
    parameter int unsigned RIDX  = RegIdxWidth
) (
    input  logic [RIDX-1:0]  src_i,
    input  logic [WIDTH-1:0] reg_data_i,
    input  logic             exmem_wb_en_i,
    input  logic [RIDX-1:0]  exmem_rd_i,
    input  logic [WIDTH-1:0] exmem_result_i,
    input  logic             exmem_r0_wr_i,
    input  logic [WIDTH-1:0] exmem_r0_i,
    input  logic             memwb_wb_en_i,
    input  logic [RIDX-1:0]  memwb_rd_i,
    input  logic [WIDTH-1:0] memwb_result_i,
    input  logic             memwb_r0_wr_i,
    input  logic [WIDTH-1:0] memwb_r0_i,
    output logic [WIDTH-1:0] data_o
);

    logic src_is_r0;
    logic exmem_r0_hit;
    logic exmem_rd_hit;
    logic memwb_r0_hit;
    logic memwb_rd_hit;

    assign src_is_r0    = (src_i == '0);
    assign exmem_r0_hit = exmem_r0_wr_i & src_is_r0;
    assign exmem_rd_hit = exmem_wb_en_i & (exmem_rd_i == src_i);
    assign memwb_r0_hit = memwb_r0_wr_i & src_is_r0;
    assign memwb_rd_hit = memwb_wb_en_i & (memwb_rd_i == src_i);

    // Within a stage the implicit R0 write wins over the rd result.
    always_comb begin
        data_o = reg_data_i;
        if (exmem_r0_hit) begin
            data_o = exmem_r0_i;
        end else if (exmem_rd_hit) begin
            data_o = exmem_result_i;
        end else if (memwb_r0_hit) begin
            data_o = memwb_r0_i;
        end else if (memwb_rd_hit) begin
            data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush squash and
// combinational operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth,
    parameter int unsigned RIDX  = RegIdxWidth
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    input  logic [3:0]       id_func,
    input  logic [RIDX-1:0]  id_rs1,
    input  logic [RIDX-1:0]  id_rs2,
    input  logic [RIDX-1:0]  id_rd,
    input  logic [WIDTH-1:0] id_rdata1,
    input  logic [WIDTH-1:0] id_rdata2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic             id_wb_en,
    input  logic             id_is_load,

    input  logic             exmem_wb_en,
    input  logic [RIDX-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             exmem_r0_wr,
    input  logic [WIDTH-1:0] exmem_r0,
    input  logic             memwb_wb_en,
    input  logic [RIDX-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    input  logic             memwb_r0_wr,
    input  logic [WIDTH-1:0] memwb_r0,

    input  logic             flush,

    output logic             stall,
    output logic             ex_valid,
    output logic [3:0]       ex_func,
    output logic [WIDTH-1:0] ex_in1,
    output logic [WIDTH-1:0] ex_in2,
    output logic [RIDX-1:0]  ex_rd,
    output logic             ex_wb_en,
    output logic             ex_is_load,
    output logic             ex_r0_wr
);

    logic             valid_q,   valid_d;
    logic [3:0]       func_q,    func_d;
    logic [RIDX-1:0]  rs1_q,     rs1_d;
    logic [RIDX-1:0]  rs2_q,     rs2_d;
    logic [RIDX-1:0]  rd_q,      rd_d;
    logic [WIDTH-1:0] rdata1_q,  rdata1_d;
    logic [WIDTH-1:0] rdata2_q,  rdata2_d;
    logic [WIDTH-1:0] imm_q,     imm_d;
    logic             use_imm_q, use_imm_d;
    logic             wb_en_q,   wb_en_d;
    logic             is_load_q, is_load_d;
    logic             r0_wr_q,   r0_wr_d;

    logic             load_hazard;
    logic             bubble;
    logic [WIDTH-1:0] fwd1;
    logic [WIDTH-1:0] fwd2;

    // A load in EX cannot supply its data until MEM/WB; hold the consumer one cycle.
    assign load_hazard = valid_q & is_load_q & wb_en_q &
                         ((rd_q == id_rs1) | ((rd_q == id_rs2) & ~id_use_imm));
    assign stall  = ~rst & id_valid & ~flush & load_hazard;
    assign bubble = flush | ~id_valid | stall;

    // Data fields are captured regardless; only the control bits mark a bubble.
    always_comb begin
        valid_d   = ~bubble;
        func_d    = id_func;
        rs1_d     = id_rs1;
        rs2_d     = id_rs2;
        rd_d      = id_rd;
        rdata1_d  = id_rdata1;
        rdata2_d  = id_rdata2;
        imm_d     = id_imm;
        use_imm_d = id_use_imm;
        wb_en_d   = ~bubble & id_wb_en;
        is_load_d = ~bubble & id_is_load;
        r0_wr_d   = ~bubble & writes_r0(id_func);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            func_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            wb_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            r0_wr_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            func_q    <= func_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            wb_en_q   <= wb_en_d;
            is_load_q <= is_load_d;
            r0_wr_q   <= r0_wr_d;
        end
    end

    fwd_mux #(
        .WIDTH (WIDTH),
        .RIDX  (RIDX)
    ) u_fwd_in1 (
        .src_i          (rs1_q),
        .reg_data_i     (rdata1_q),
        .exmem_wb_en_i  (exmem_wb_en),
        .exmem_rd_i     (exmem_rd),
        .exmem_result_i (exmem_result),
        .exmem_r0_wr_i  (exmem_r0_wr),
        .exmem_r0_i     (exmem_r0),
        .memwb_wb_en_i  (memwb_wb_en),
        .memwb_rd_i     (memwb_rd),
        .memwb_result_i (memwb_result),
        .memwb_r0_wr_i  (memwb_r0_wr),
        .memwb_r0_i     (memwb_r0),
        .data_o         (fwd1)
    );

    fwd_mux #(
        .WIDTH (WIDTH),
        .RIDX  (RIDX)
    ) u_fwd_in2 (
        .src_i          (rs2_q),
        .reg_data_i     (rdata2_q),
        .exmem_wb_en_i  (exmem_wb_en),
        .exmem_rd_i     (exmem_rd),
        .exmem_result_i (exmem_result),
        .exmem_r0_wr_i  (exmem_r0_wr),
        .exmem_r0_i     (exmem_r0),
        .memwb_wb_en_i  (memwb_wb_en),
        .memwb_rd_i     (memwb_rd),
        .memwb_result_i (memwb_result),
        .memwb_r0_wr_i  (memwb_r0_wr),
        .memwb_r0_i     (memwb_r0),
        .data_o         (fwd2)
    );

    assign ex_valid   = valid_q;
    assign ex_func    = func_q;
    assign ex_in1     = fwd1;
    assign ex_in2     = use_imm_q ? imm_q : fwd2;
    assign ex_rd      = rd_q;
    assign ex_wb_en   = wb_en_q;
    assign ex_is_load = is_load_q;
    assign ex_r0_wr   = r0_wr_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the datapath width.
REQ-002 SHALL have parameter RIDX, default 4, giving the register-index width (16 architectural registers, R0 = index 0).
REQ-003 SHALL have ports clk input 1 (sole clock, rising edge) and rst input 1 (asynchronous, active-high reset).
REQ-004 SHALL have decode inputs id_valid 1, id_func 4, id_rs1/id_rs2/id_rd RIDX, id_rdata1/id_rdata2 WIDTH, id_imm WIDTH, id_use_imm 1, id_wb_en 1, id_is_load 1.
REQ-005 SHALL have forwarding inputs exmem_wb_en 1, exmem_rd RIDX, exmem_result WIDTH, exmem_r0_wr 1, exmem_r0 WIDTH, plus memwb_wb_en, memwb_rd, memwb_result, memwb_r0_wr, memwb_r0 of the same widths.
REQ-006 SHALL have input flush 1 (taken branch; squash the ID instruction).
REQ-007 SHALL have outputs stall 1 (hold PC and IF/ID), ex_valid 1, ex_func 4, ex_in1/ex_in2 WIDTH (ALU operands), ex_rd RIDX, ex_wb_en 1, ex_is_load 1, ex_r0_wr 1.

Function
REQ-008 SHALL register id_* fields into the EX register on every rising clk edge unless a bubble is inserted.
REQ-009 SHALL insert a bubble (ex_valid=0, ex_wb_en=0, ex_is_load=0, ex_r0_wr=0, other fields don't-care) when flush=1, id_valid=0 or stall=1.
REQ-010 SHALL assert stall combinationally when id_valid=1, flush=0, ex_valid=1, ex_is_load=1, ex_wb_en=1 and ex_rd equals id_rs1, or equals id_rs2 with id_use_imm=0.
REQ-011 SHALL hold stall to exactly one cycle per load-use hazard: the bubble clears the condition on the next edge.
REQ-012 SHALL drive stall=0 whenever flush=1 (flush has priority).
REQ-013 SHALL set ex_r0_wr=1 for registered func 4'b0001 (multiply) or 4'b0010 (divide); these write R0 implicitly.
REQ-014 SHALL form ex_in1 from the registered rs1 data, replaced by the youngest matching forward: EX/MEM before MEM/WB before register data.
REQ-015 SHALL treat a stage as matching source s when (wb_en=1 and rd==s) or (r0_wr=1 and s==0); within one stage, r0_wr with s==0 supplies the r0 value over result.
REQ-016 SHALL form ex_in2 the same way from rs2, except that when the registered use_imm=1, ex_in2 is the registered immediate with no forwarding.
REQ-017 SHALL make the forwarding muxes purely combinational on the registered indices and current forwarding inputs (zero added latency).
REQ-018 SHALL have a latency of one cycle from ID inputs to ex_* outputs, with throughput of one instruction per cycle absent stalls.
REQ-019 SHALL pass all WIDTH-bit values unmodified; no sign extension or truncation occurs in this block.

Reset
REQ-020 SHALL, on rst=1, asynchronously clear ex_valid, ex_wb_en, ex_is_load, ex_r0_wr, ex_func, ex_rd and the registered data/immediate to 0.
REQ-021 SHALL drive stall=0 while rst=1; reset mid-stall drops the held instruction (it is not replayed).
REQ-022 SHALL resume capture on the first rising edge after rst deasserts.

Structure
REQ-023 SHALL take the function-code constants (ADD 1111, SUB 1110, AND 1101, OR 1100, MUL 0001, DIV 0010, SHL 1010, SHR 1011, ROL 1000, ROR 1001), WIDTH and RIDX defaults from the shared package cpu_pkg.
REQ-024 SHALL instantiate the sub-module fwd_mux twice, once per operand, to implement REQ-014 and REQ-015.

Verification
REQ-025 SHALL include a test where back-to-back ADD writes R3=0x0005, then SUB reads rs1=3 with stale regfile value 0x0000; ex_in1 must equal 0x0005 via EX/MEM.
REQ-026 SHALL include a test where a LOAD writes R4, then ADD reads rs2=4; stall=1 for one cycle, one bubble enters, and ex_in2 is then taken from memwb_result (0x1234).
REQ-027 SHALL include a test where MUL in EX/MEM has exmem_r0_wr=1, exmem_r0=0x00FF and the next instruction reads rs1=0; ex_in1 must equal 0x00FF.
REQ-028 SHALL include a test where EX/MEM and MEM/WB both target R7 (0xAAAA, 0x5555); ex_in1 must equal 0xAAAA.
REQ-029 SHALL include a test asserting flush together with a load-use hazard; stall must be 0 and ex_valid must be 0 on the next cycle.
REQ-030 SHALL include a test asserting rst mid-stall; ex_valid must fall immediately without waiting for clk, and stall must go to 0.
